// File: rtl/useq_loader_if.sv
// Byte-stream and program-fetch signals between useq_loader, its byte source
// (e.g. a UART receiver) and the useq fetch port.
interface useq_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;

  modport master (
    output s_data,
    output s_valid,
    output mem_addr,
    input  s_ready,
    input  mem_data
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  mem_addr,
    output s_ready,
    output mem_data
  );
endinterface

// File: rtl/useq_loader.sv
// Program store and framed byte-stream boot loader for the useq sequencer.
// Define USEQ_LOADER_CSUM_EN to add the trailing checksum byte and err flag.
module useq_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  useq_loader_if.slave      bus,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef USEQ_LOADER_CSUM_EN
  typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} state_e;
`else
  typedef enum logic [1:0] {IDLE, LEN, DATA} state_e;
`endif

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] wptr_q, wptr_d;
  logic       run_q, run_d;
  logic       done_q, done_d;
  logic       ready_q;
  logic       accept;
  logic       we;
`ifdef USEQ_LOADER_CSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] csumTotal;
  logic       err_q, err_d;
`endif

  logic [7:0] mem_q [DEPTH];

  assign accept = bus.s_valid & ready_q;
`ifdef USEQ_LOADER_CSUM_EN
  assign csumTotal = sum_q + bus.s_data;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    run_d   = run_q;
    done_d  = 1'b0;
    we      = 1'b0;
`ifdef USEQ_LOADER_CSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (bus.s_data == SYNC_BYTE) begin
            state_d = LEN;
            run_d   = 1'b0;
`ifdef USEQ_LOADER_CSUM_EN
            err_d   = 1'b0;
`endif
          end
        end
        LEN: begin
          // A length byte of zero encodes a full 256-byte image.
          cnt_d   = (bus.s_data == 8'd0) ? 9'd256 : {1'b0, bus.s_data};
          wptr_d  = 8'd0;
`ifdef USEQ_LOADER_CSUM_EN
          sum_d   = 8'd0;
`endif
          state_d = DATA;
        end
        DATA: begin
          we     = 1'b1;
          wptr_d = wptr_q + 8'd1;
          cnt_d  = cnt_q - 9'd1;
`ifdef USEQ_LOADER_CSUM_EN
          sum_d  = sum_q + bus.s_data;
`endif
          if (cnt_q == 9'd1) begin
`ifdef USEQ_LOADER_CSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
            run_d   = 1'b1;
`endif
          end
        end
`ifdef USEQ_LOADER_CSUM_EN
        CSUM: begin
          state_d = IDLE;
          if (csumTotal == 8'd0) begin
            done_d = 1'b1;
            run_d  = 1'b1;
            err_d  = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 9'd0;
      wptr_q  <= 8'd0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef USEQ_LOADER_CSUM_EN
      sum_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      run_q   <= run_d;
      done_q  <= done_d;
      ready_q <= 1'b1;
`ifdef USEQ_LOADER_CSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  // The store has no reset so an aborted load leaves its partial writes behind.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wptr_q] <= bus.s_data;
    end
  end

  assign bus.s_ready  = ready_q;
  assign bus.mem_data = mem_q[bus.mem_addr];
  assign core_rst_n   = run_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
`ifdef USEQ_LOADER_CSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule
